rfsrc_write_sched: RTL
======================

// Module: rfsrc_write_sched
// PURPOSE
//  Sequences all writes into the single-write-port register-source (rename map) table.
//  Accepts a per-cycle rename bundle of up to QSLOTS destination writes and serializes it, one write per cycle, in slot order.
//  Also performs the post-reset table sweep and replays branch-miss restore entries.
//  Sits between the queue/rename stage and the rf_source table; replaces the per-phase ack handshake with valid/ready.
// PARAMETERS
//  AREGS          4096  architectural register count (table depth)
//  RBIT           11    MSB of register index
//  QSLOTS         4     rename slots per bundle
//  TAGW           5     ROB tag width
// PORTS
//  clk       in   1                clock
//  rst       in   1                reset, synchronous, active-high
//  bnd_valid in   1                rename bundle present
//  bnd_ready out  1                bundle accepted when valid&ready
//  bnd_mask  in   QSLOTS           per-slot register-write request
//  bnd_rd    in   QSLOTS*(RBIT+1)  per-slot destination register, slot0 in LSBs
//  bnd_tag   in   QSLOTS*TAGW      per-slot ROB tag
//  branchmiss in  1                flush request
//  rs_valid  in   1                restore entry present
//  rs_ready  out  1                restore entry accepted when valid&ready
//  rs_rd     in   RBIT+1           restore destination register
//  rs_tag    in   TAGW             restore ROB tag
//  rs_last   in   1                final restore entry
//  tbl_we    out  1                table write enable
//  tbl_wa    out  RBIT+1           table write address
//  tbl_wd    out  TAGW+1           table write data; {1'b0,tag} = pending, all-ones = architectural
//  init_done out  1                sweep complete
//  busy      out  1                state != IDLE
// BEHAVIOUR
//  - States: INIT, IDLE, ISSUE, FLUSH. tbl_* are combinational from state registers.
//  - rst high: next state INIT, sweep counter 0, rem mask 0, init_done 0; tbl_we, bnd_ready and rs_ready forced 0 while rst is high.
//    rst mid-operation aborts everything and restarts the sweep at address 0.
//  - INIT: writes one address per cycle, wa = counter, wd = all-ones, addresses 0..AREGS-1.
//    On the write to AREGS-1: next state IDLE, init_done=1 from the following cycle (sticky until rst).
//    branchmiss ignored; bnd_ready=0, rs_ready=0.
//  - Accept filter: rem <= bnd_mask & ~(slot rd==0), plus latched rd/tag. Register 0 is never written.
//    Filtered mask 0 -> no writes, stay/return IDLE.
//  - IDLE: tbl_we=0; bnd_ready = ~branchmiss.
//  - ISSUE: each cycle tbl_we=1, wa = rd[i], wd = {1'b0,tag[i]}, where i = lowest set bit of rem; that bit is cleared.
//    Lower slot writes first, so duplicate Rd gives the highest-slot tag.
//    bnd_ready = (popcount(rem)==1) & ~branchmiss: a bundle accepted in cycle N with k writes drives writes in N+1..N+k.
//    A new bundle accepted in N+k starts at N+k+1 with no bubble. rem empty with no new bundle -> IDLE.
//  - branchmiss (IDLE/ISSUE): rem cleared in the same cycle; the write for that cycle is still emitted.
//    Next state FLUSH. branchmiss has priority over a simultaneous bundle: bundle not accepted.
//  - FLUSH: rs_ready=1, bnd_ready=0; each accepted restore drives the same-cycle write (rs_rd, {1'b0,rs_tag}).
//    Entries with rs_rd==0 are accepted, not written. Accepted entry with rs_last -> IDLE next cycle.
//    branchmiss during FLUSH: no effect. rs_valid low: no write, stay.
//  - busy = (state != IDLE); the sweep counter wraps never, is width RBIT+1, and is compared to AREGS-1.
// STRUCTURE
//  - Package rfsrc_pkg: TAGW, ARCH_TAG (all-ones), rfsrc_state_e enum, bundle struct (mask/rd/tag arrays).
//  - Sub-module rfsrc_lowbit_pick: QSLOTS-wide lowest-set-bit one-hot + index, used to pick the ISSUE slot.
// TESTING
//  1. AREGS=16, rst 1 cycle -> 16 consecutive writes wa 0..15, wd=6'h3F; init_done high the cycle after wa=15.
//  2. IDLE, mask 1011, rd0=7/rd1=5/rd3=9, tags 0/1/3 -> writes (7,0),(5,1),(9,3) in 3 consecutive cycles; bnd_ready high in the 3rd.
//  3. mask 0101, rd0=rd2=4, tags 2/6 -> writes (4,2) then (4,6); final table value 6.
//  4. mask 0011, rd1=0 -> single write for slot0. mask 0001 with rd0=0 -> no write; busy stays 0.
//  5. mask 1111 -> branchmiss with 2nd write: that write occurs, slots 2-3 dropped.
//     3 restores, rs_last on 3rd -> 3 writes, then IDLE.
//  6. Two back-to-back 1111 bundles -> 8 writes in 8 consecutive cycles, no bubble.

Source files
------------

// File: rtl/rfsrc_pkg.sv
// rfsrc_pkg
//   Shared definitions for the rename-map (rf_source) write scheduler:
//   slot/field widths, the architectural marker written by the sweep,
//   the scheduler state encoding and the rename bundle layout.
package rfsrc_pkg;

  localparam int RBIT    = 11;               // MSB of register index
  localparam int QSLOTS  = 4;                // rename slots per bundle
  localparam int TAGW    = 5;                // ROB tag width
  localparam int SLOT_IW = $clog2(QSLOTS);   // slot index width

  // Entry value meaning "register holds its architectural value".
  localparam logic [TAGW:0] ARCH_TAG = '1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_FLUSH
  } rfsrc_state_e;

  // Slot 0 occupies the least significant bits of each field.
  typedef struct packed {
    logic [QSLOTS-1:0]            mask;
    logic [QSLOTS-1:0][RBIT:0]    rd;
    logic [QSLOTS-1:0][TAGW-1:0]  tag;
  } rfsrc_bundle_t;

  // Per-slot flag: destination is not register 0 (which is never mapped).
  function automatic logic [QSLOTS-1:0] rd_nonzero(input logic [QSLOTS-1:0][RBIT:0] rd);
    logic [QSLOTS-1:0] nz;
    for (int s = 0; s < QSLOTS; s++) begin
      nz[s] = |rd[s];
    end
    return nz;
  endfunction

endpackage

// File: rtl/rfsrc_lowbit_pick.sv
// rfsrc_lowbit_pick
//   Picks the lowest set bit of a QSLOTS-wide request vector.
//   Ports:
//     i_req     in   QSLOTS    request bits
//     o_onehot  out  QSLOTS    one-hot of the lowest set request bit (0 if none)
//     o_idx     out  SLOT_IW   index of that bit (0 if none)
//     o_any     out  1         at least one request set
module rfsrc_lowbit_pick
  import rfsrc_pkg::*;
(
  input  logic [QSLOTS-1:0]  i_req,
  output logic [QSLOTS-1:0]  o_onehot,
  output logic [SLOT_IW-1:0] o_idx,
  output logic               o_any
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    for (int i = QSLOTS-1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = SLOT_IW'(i);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/rfsrc_write_sched.sv
// rfsrc_write_sched
//   Serializes every write into the single-write-port rename map table:
//   the post-reset sweep, rename bundles (one slot per cycle, slot order)
//   and branch-miss restore replay.
//   Ports:
//     clk, rst              clock; synchronous active-high reset
//     i_bnd_valid/o_bnd_ready   rename bundle handshake
//     i_bnd_mask/rd/tag     per-slot write request, destination, ROB tag
//     i_branchmiss          flush request
//     i_rs_valid/o_rs_ready restore entry handshake
//     i_rs_rd/tag/last      restore destination, tag, final-entry flag
//     o_tbl_we/wa/wd        table write port
//     o_init_done           sweep complete (sticky until rst)
//     o_busy                scheduler not idle
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_INIT  | sweeping every address to ARCH_TAG, one per cycle
//   ST_IDLE  | no pending writes, bundle may be accepted
//   ST_ISSUE | draining latched bundle slots, lowest slot first
//   ST_FLUSH | replaying restore entries until rs_last is accepted
module rfsrc_write_sched
  import rfsrc_pkg::*;
#(
  parameter int AREGS = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_bnd_valid,
  output logic                     o_bnd_ready,
  input  logic [QSLOTS-1:0]        i_bnd_mask,
  input  logic [QSLOTS*(RBIT+1)-1:0] i_bnd_rd,
  input  logic [QSLOTS*TAGW-1:0]   i_bnd_tag,
  input  logic                     i_branchmiss,
  input  logic                     i_rs_valid,
  output logic                     o_rs_ready,
  input  logic [RBIT:0]            i_rs_rd,
  input  logic [TAGW-1:0]          i_rs_tag,
  input  logic                     i_rs_last,
  output logic                     o_tbl_we,
  output logic [RBIT:0]            o_tbl_wa,
  output logic [TAGW:0]            o_tbl_wd,
  output logic                     o_init_done,
  output logic                     o_busy
);

  localparam int unsigned  LAST_I    = AREGS - 1;
  localparam logic [RBIT:0] LAST_ADDR = LAST_I[RBIT:0];

  rfsrc_state_e                r_state;
  logic [RBIT:0]               r_cnt;
  logic [QSLOTS-1:0]           r_rem;
  logic [QSLOTS-1:0][RBIT:0]   r_rd;
  logic [QSLOTS-1:0][TAGW-1:0] r_tag;
  logic                        r_init_done;

  rfsrc_state_e      w_state_nxt;
  logic [QSLOTS-1:0] w_rem_nxt;
  logic [QSLOTS-1:0] w_rem_left;
  logic [QSLOTS-1:0] w_keep;
  logic              w_load;
  logic              w_sweep_end;
  logic              w_last_one;
  logic              w_we;
  logic [RBIT:0]     w_wa;
  logic [TAGW:0]     w_wd;
  logic              w_bnd_ready;
  logic              w_rs_ready;
  rfsrc_bundle_t     w_bnd;

  logic [QSLOTS-1:0]  w_pick_oh;
  logic [SLOT_IW-1:0] w_pick_idx;
  logic               w_pick_any;

  always_comb begin
    w_bnd.mask = i_bnd_mask;
    w_bnd.rd   = i_bnd_rd;
    w_bnd.tag  = i_bnd_tag;
  end

  // Register 0 is never written, so its slots are dropped at accept time.
  assign w_keep     = w_bnd.mask & rd_nonzero(w_bnd.rd);
  assign w_rem_left = r_rem & ~w_pick_oh;
  assign w_last_one = ($countones(r_rem) == 1);

  rfsrc_lowbit_pick u_pick (
    .i_req    (r_rem),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_load      = 1'b0;
    w_sweep_end = 1'b0;
    w_we        = 1'b0;
    w_wa        = r_cnt;
    w_wd        = ARCH_TAG;
    w_bnd_ready = 1'b0;
    w_rs_ready  = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_we = 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_sweep_end = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_IDLE: begin
        w_bnd_ready = ~i_branchmiss;
        if (i_branchmiss) begin
          w_rem_nxt   = '0;
          w_state_nxt = ST_FLUSH;
        end else if (i_bnd_valid) begin
          w_load      = 1'b1;
          w_rem_nxt   = w_keep;
          w_state_nxt = (|w_keep) ? ST_ISSUE : ST_IDLE;
        end
      end

      ST_ISSUE: begin
        // Current write always goes out, even when a flush arrives with it.
        w_we        = w_pick_any;
        w_wa        = r_rd[w_pick_idx];
        w_wd        = {1'b0, r_tag[w_pick_idx]};
        w_bnd_ready = w_last_one & ~i_branchmiss;
        if (i_branchmiss) begin
          w_rem_nxt   = '0;
          w_state_nxt = ST_FLUSH;
        end else if (i_bnd_valid && w_last_one) begin
          w_load      = 1'b1;
          w_rem_nxt   = w_keep;
          w_state_nxt = (|w_keep) ? ST_ISSUE : ST_IDLE;
        end else begin
          w_rem_nxt   = w_rem_left;
          w_state_nxt = (|w_rem_left) ? ST_ISSUE : ST_IDLE;
        end
      end

      ST_FLUSH: begin
        w_rs_ready = 1'b1;
        w_wa       = i_rs_rd;
        w_wd       = {1'b0, i_rs_tag};
        if (i_rs_valid) begin
          w_we = |i_rs_rd;
          if (i_rs_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase

    if (rst) begin
      w_we        = 1'b0;
      w_bnd_ready = 1'b0;
      w_rs_ready  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      // Counter holds at the last address instead of wrapping.
      if (r_state == ST_INIT && !w_sweep_end) begin
        r_cnt <= r_cnt + {{RBIT{1'b0}}, 1'b1};
      end
      if (w_sweep_end) begin
        r_init_done <= 1'b1;
      end
    end
  end

  // Slot payload only matters while its rem bit is set, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_rd  <= w_bnd.rd;
      r_tag <= w_bnd.tag;
    end
  end

  assign o_tbl_we    = w_we;
  assign o_tbl_wa    = w_wa;
  assign o_tbl_wd    = w_wd;
  assign o_bnd_ready = w_bnd_ready;
  assign o_rs_ready  = w_rs_ready;
  assign o_init_done = r_init_done;
  assign o_busy      = (r_state != ST_IDLE);

endmodule
